// File: rtl/fifo_traffic_gen_if.sv
// Producer-side bus between the traffic generator and the FIFO block,
// plus the scoreboard start pulse and per-FIFO FSM state for debug.
interface fifo_traffic_gen_if #(
  parameter int NUM_REQS = 2,
  parameter int WIDTH    = 8,
  parameter int IDW      = 1,
  parameter int BLW      = 4
);
  logic                      en;
  logic [BLW-1:0]            burst_len;
  logic [BLW-1:0]            gap_len;
  logic [NUM_REQS-1:0]       full;
  logic [WIDTH-IDW-1:0]      mark_seq;
  logic [NUM_REQS-1:0]       push;
  logic [NUM_REQS*WIDTH-1:0] flat_data_out;
  logic                      start;
  logic [2*NUM_REQS-1:0]     state_dbg;

  // Handshake: push[i] is the valid strobe and ~full[i] is ready; a word on
  // slice i transfers only in a cycle where push[i] & ~full[i], and the
  // generator never raises push[i] while full[i] is high.
  modport master (
    input  en, burst_len, gap_len, full, mark_seq,
    output push, flat_data_out, start, state_dbg
  );

  modport slave (
    output en, burst_len, gap_len, full, mark_seq,
    input  push, flat_data_out, start, state_dbg
  );
endinterface

// File: rtl/fifo_traffic_gen.sv
// Burst/gap traffic generator: one independent IDLE/BURST/GAP FSM per FIFO,
// pushing self-describing {fifo index, sequence number} words.
module fifo_traffic_gen #(
  parameter int NUM_REQS = 2,
  parameter int WIDTH    = 8,
  parameter int IDW      = 1,
  parameter int BLW      = 4,
  parameter int FIFO_SEL = 0
) (
  input  logic              clk,
  input  logic              rst,
  fifo_traffic_gen_if.master bus
);
  localparam int SEQW = WIDTH - IDW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  logic [NUM_REQS-1:0]       push;
  logic [NUM_REQS-1:0]       mark_hit;
  logic [NUM_REQS*WIDTH-1:0] flat_data;
  logic [2*NUM_REQS-1:0]     state_flat;
  logic [BLW-1:0]            burst_load;
  logic                      start;
  logic                      marked_q;

  // A zero burst length still produces one word per burst.
  assign burst_load = (bus.burst_len == '0) ? BLW'(1) : bus.burst_len;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_fifo
    state_e          state_q;
    logic [SEQW-1:0] seq_q;
    logic [BLW-1:0]  beat_q;
    logic [BLW-1:0]  gap_q;

    assign push[g]                      = (state_q == BURST) & bus.en & ~bus.full[g];
    assign mark_hit[g]                  = (seq_q == bus.mark_seq);
    assign flat_data[g*WIDTH +: WIDTH]  = {IDW'(g), seq_q};
    assign state_flat[2*g +: 2]         = state_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        seq_q   <= '0;
        beat_q  <= '0;
        gap_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.en) begin
              state_q <= BURST;
              beat_q  <= burst_load;
            end
          end
          BURST: begin
            // Stalls (full or en low) hold seq and beat: the burst stretches.
            if (push[g]) begin
              seq_q <= seq_q + SEQW'(1);
              if (beat_q == BLW'(1)) begin
                if (bus.gap_len == '0) begin
                  beat_q <= burst_load;
                end else begin
                  state_q <= GAP;
                  gap_q   <= bus.gap_len;
                  beat_q  <= '0;
                end
              end else begin
                beat_q <= beat_q - BLW'(1);
              end
            end
          end
          GAP: begin
            if (bus.en) begin
              if (gap_q == BLW'(1)) begin
                state_q <= BURST;
                beat_q  <= burst_load;
              end else begin
                gap_q <= gap_q - BLW'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // marked is sticky so start fires once per reset, even after sequence wrap.
  assign start = push[FIFO_SEL] & mark_hit[FIFO_SEL] & ~marked_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      marked_q <= 1'b0;
    end else if (start) begin
      marked_q <= 1'b1;
    end
  end

  assign bus.push          = push;
  assign bus.flat_data_out = flat_data;
  assign bus.start         = start;
  assign bus.state_dbg     = state_flat;
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench for fifo_traffic_gen: table-driven burst/backpressure/enable
// vectors, a long wrap/marker run, and asynchronous reset checks.
module tb_fifo_traffic_gen;
  localparam int NUM_REQS = 2;
  localparam int WIDTH    = 8;
  localparam int IDW      = 1;
  localparam int BLW      = 4;

  logic clk;
  logic rst;

  fifo_traffic_gen_if #(.NUM_REQS(NUM_REQS), .WIDTH(WIDTH), .IDW(IDW), .BLW(BLW)) bus ();

  fifo_traffic_gen #(
    .NUM_REQS(NUM_REQS), .WIDTH(WIDTH), .IDW(IDW), .BLW(BLW), .FIFO_SEL(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic             sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && !rst && bus.push[0]) got_q.push_back(bus.flat_data_out[WIDTH-1:0]);
  end

  typedef struct {
    logic                en;
    logic [BLW-1:0]      bl;
    logic [BLW-1:0]      gl;
    logic [NUM_REQS-1:0] full;
    logic [NUM_REQS-1:0] push;
    logic [WIDTH-1:0]    d0;
    logic [WIDTH-1:0]    d1;
    logic                start;
  } vec_t;

  vec_t vecs[18];

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [BLW-1:0] bl, input logic [BLW-1:0] gl,
                       input logic [NUM_REQS-1:0] full);
    bus.en        = en;
    bus.burst_len = bl;
    bus.gap_len   = gl;
    bus.full      = full;
  endtask

  task automatic check_outs(input string tag, input logic [NUM_REQS-1:0] push,
                            input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic start);
    check({tag, " push"},  32'(bus.push), 32'(push));
    check({tag, " d0"},    32'(bus.flat_data_out[WIDTH-1:0]), 32'(d0));
    check({tag, " d1"},    32'(bus.flat_data_out[2*WIDTH-1:WIDTH]), 32'(d1));
    check({tag, " start"}, 32'(bus.start), 32'(start));
    check({tag, " push&full"}, 32'(bus.push & bus.full), 32'd0);
  endtask

  // Asserts reset asynchronously in the middle of a cycle and checks that
  // outputs respond before any clock edge; returns released at posedge+1.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, " rst push"},  32'(bus.push), 32'd0);
    check({tag, " rst flat"},  32'(bus.flat_data_out), 32'h8000);
    check({tag, " rst start"}, 32'(bus.start), 32'd0);
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    bus.mark_seq = 7'd2;
    drive(1'b0, 4'd0, 4'd0, 2'b00);

    //            en bl    gl    full   push   d0     d1     start
    vecs[0]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b00, 8'h00, 8'h80, 1'b0};
    vecs[1]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b11, 8'h00, 8'h80, 1'b0};
    vecs[2]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b11, 8'h01, 8'h81, 1'b0};
    vecs[3]  = '{1'b1, 4'd3, 4'd2, 2'b01, 2'b10, 8'h02, 8'h82, 1'b0};
    vecs[4]  = '{1'b1, 4'd3, 4'd2, 2'b01, 2'b00, 8'h02, 8'h83, 1'b0};
    vecs[5]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b01, 8'h02, 8'h83, 1'b1};
    vecs[6]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b10, 8'h03, 8'h83, 1'b0};
    vecs[7]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b10, 8'h03, 8'h84, 1'b0};
    vecs[8]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b11, 8'h03, 8'h85, 1'b0};
    vecs[9]  = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b01, 8'h04, 8'h86, 1'b0};
    vecs[10] = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b01, 8'h05, 8'h86, 1'b0};
    vecs[11] = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b10, 8'h06, 8'h86, 1'b0};
    vecs[12] = '{1'b0, 4'd3, 4'd2, 2'b00, 2'b00, 8'h06, 8'h87, 1'b0};
    vecs[13] = '{1'b0, 4'd3, 4'd2, 2'b00, 2'b00, 8'h06, 8'h87, 1'b0};
    vecs[14] = '{1'b0, 4'd3, 4'd2, 2'b00, 2'b00, 8'h06, 8'h87, 1'b0};
    vecs[15] = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b10, 8'h06, 8'h87, 1'b0};
    vecs[16] = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b11, 8'h06, 8'h88, 1'b0};
    vecs[17] = '{1'b1, 4'd3, 4'd2, 2'b00, 2'b01, 8'h07, 8'h89, 1'b0};

    for (int w = 0; w < 8; w++) exp_q.push_back(8'(w));

    #2;
    do_reset("init");

    // Bursts, backpressure on FIFO0, marker, enable gating mid-gap/mid-burst.
    sb_on = 1'b1;
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].bl, vecs[i].gl, vecs[i].full);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].push, vecs[i].d0, vecs[i].d1, vecs[i].start);
      next_cycle();
    end
    sb_on = 1'b0;

    while (exp_q.size() > 0) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check("sb missing", 32'hFFFF_FFFF, 32'(e));
      end else begin
        check("sb word", 32'(got_q.pop_front()), 32'(e));
      end
    end
    check("sb extra", 32'(got_q.size()), 32'd0);

    // Degenerate lengths: push every cycle, sequence wraps, start fires once.
    drive(1'b0, 4'd0, 4'd0, 2'b00);
    do_reset("wrap");
    drive(1'b1, 4'd0, 4'd0, 2'b00);
    for (int k = 0; k < 134; k++) begin
      logic [6:0] s;
      s = (k == 0) ? 7'd0 : 7'((k - 1) % 128);
      @(negedge clk);
      check_outs($sformatf("wrap%0d", k), (k == 0) ? 2'b00 : 2'b11,
                 {1'b0, s}, {1'b1, s}, (k == 3));
      next_cycle();
    end

    // Reset in the middle of back-to-back bursts, then restart from seq 0.
    do_reset("midburst");
    @(negedge clk);
    check_outs("restart0", 2'b00, 8'h00, 8'h80, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("restart1", 2'b11, 8'h00, 8'h80, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("restart2", 2'b11, 8'h01, 8'h81, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
